// File: rtl/atan2_arbiter_if.sv
// Requester-side bus of the Arctan2 arbiter: per-requester job requests,
// accept strobes and the shared, one-hot-qualified result.
interface atan2_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_arg1;
  logic [NUM_REQ*64-1:0] req_arg2;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic signed [12:0]    rsp_angle;
  logic                  rsp_timeout;

  modport master (
    output req_valid, req_arg1, req_arg2,
    input  req_ready, rsp_valid, rsp_angle, rsp_timeout
  );

  modport slave (
    input  req_valid, req_arg1, req_arg2,
    output req_ready, rsp_valid, rsp_angle, rsp_timeout
  );
endinterface

// File: rtl/atan2_arbiter.sv
// Round-robin arbiter sharing one Arctan2 core between NUM_REQ requesters,
// with per-job core reset sequencing, result steering and a run watchdog.
module atan2_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 511
) (
  input  logic               clk,
  input  logic               reset_n,
  atan2_arbiter_if.slave     bus,
  output logic               busy,
  output logic [63:0]        core_arg1,
  output logic [63:0]        core_arg2,
  output logic               core_enable,
  output logic               core_reset,
  input  logic signed [12:0] core_angle,
  input  logic               core_done
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [12:0] rsp_angle_q, rsp_angle_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               armed_q;
  logic [63:0]        arg1_q, arg2_q;
  logic [63:0]        sel_arg1, sel_arg2;
  logic [GW-1:0]      pick;
  logic               accept;

  // First set request bit strictly after 'last', wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] w;
    logic          hit;
    int            idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && v[GW'(idx)]) begin
        w   = GW'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  // armed_q keeps req_ready low while reset is asserted and for the first
  // cycle after release, without feeding reset_n into the datapath.
  assign pick   = rr_pick(bus.req_valid, last_grant_q);
  assign accept = (state_q == IDLE) && armed_q && (|bus.req_valid);

  always_comb begin
    sel_arg1 = '0;
    sel_arg2 = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick == GW'(r)) begin
        sel_arg1 = bus.req_arg1[r*64 +: 64];
        sel_arg2 = bus.req_arg2[r*64 +: 64];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    cnt_d         = cnt_q;
    rsp_angle_d   = rsp_angle_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = pick;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // A done seen in the first RUN cycle is a leftover from the previous job.
        if (core_done && (cnt_q != '0)) begin
          rsp_angle_d   = core_angle;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_angle_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      cnt_q         <= '0;
      rsp_angle_q   <= '0;
      rsp_timeout_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      rsp_angle_q   <= rsp_angle_d;
      rsp_timeout_q <= rsp_timeout_d;
      armed_q       <= 1'b1;
    end
  end

  // Arguments are captured at accept so requesters may change them freely.
  always_ff @(posedge clk) begin
    if (accept) begin
      arg1_q <= sel_arg1;
      arg2_q <= sel_arg2;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (accept)           bus.req_ready[pick]       = 1'b1;
    if (state_q == RESP)  bus.rsp_valid[grant_id_q] = 1'b1;
  end

  assign bus.rsp_angle   = rsp_angle_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign busy            = (state_q != IDLE);
  assign core_enable     = (state_q == RUN);
  assign core_reset      = (state_q != RUN);
  assign core_arg1       = (state_q == RUN) ? arg1_q : '0;
  assign core_arg2       = (state_q == RUN) ? arg2_q : '0;

endmodule

// File: tb/tb_atan2_arbiter.sv
// Randomized scoreboard bench for atan2_arbiter: two instances (long and short
// watchdog) each driven against a behavioural core stub and job-level model.
module tb_atan2_arbiter;
  localparam int N    = 3;
  localparam int TO_A = 511;
  localparam int TO_B = 15;

  typedef struct {
    int                 id;
    logic signed [12:0] angle;
    logic               tmo;
    int                 cyc;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  atan2_arbiter_if #(.NUM_REQ(N)) bus0 ();
  atan2_arbiter_if #(.NUM_REQ(N)) bus1 ();

  logic [N-1:0]       rv   [2];
  logic [N*64-1:0]    a1   [2];
  logic [N*64-1:0]    a2   [2];
  logic [N-1:0]       rdy  [2];
  logic [N-1:0]       rspv [2];
  logic signed [12:0] ang  [2];
  logic               tmo  [2];
  logic               busy [2];
  logic               cen  [2];
  logic               crst [2];
  logic               cdone[2];
  logic [63:0]        ca1  [2];
  logic [63:0]        ca2  [2];
  logic signed [12:0] cang [2];

  assign bus0.req_valid = rv[0];
  assign bus0.req_arg1  = a1[0];
  assign bus0.req_arg2  = a2[0];
  assign bus1.req_valid = rv[1];
  assign bus1.req_arg1  = a1[1];
  assign bus1.req_arg2  = a2[1];
  assign rdy[0]  = bus0.req_ready;
  assign rspv[0] = bus0.rsp_valid;
  assign ang[0]  = bus0.rsp_angle;
  assign tmo[0]  = bus0.rsp_timeout;
  assign rdy[1]  = bus1.req_ready;
  assign rspv[1] = bus1.rsp_valid;
  assign ang[1]  = bus1.rsp_angle;
  assign tmo[1]  = bus1.rsp_timeout;

  atan2_arbiter #(.NUM_REQ(N), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .busy(busy[0]),
    .core_arg1(ca1[0]), .core_arg2(ca2[0]), .core_enable(cen[0]),
    .core_reset(crst[0]), .core_angle(cang[0]), .core_done(cdone[0])
  );

  atan2_arbiter #(.NUM_REQ(N), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .busy(busy[1]),
    .core_arg1(ca1[1]), .core_arg2(ca2[1]), .core_enable(cen[1]),
    .core_reset(crst[1]), .core_angle(cang[1]), .core_done(cdone[1])
  );

  // Core stub: done rises 'stub_l' cycles after the core leaves reset.
  int                 stub_l    [2];
  logic signed [12:0] stub_ang  [2];
  logic               stub_never[2];
  logic               stub_stale[2];
  int                 run_cnt   [2];

  always @(posedge clk)
    for (int i = 0; i < 2; i++) run_cnt[i] <= crst[i] ? 0 : run_cnt[i] + 1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cang[i]  = stub_ang[i];
      cdone[i] = !crst[i] && ((!stub_never[i] && (run_cnt[i] == stub_l[i])) ||
                              (stub_stale[i] && (run_cnt[i] == 0)));
    end
  end

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   model_last[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Monitor: pops the scoreboard whenever a result strobe appears.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   qs;
    for (int i = 0; i < 2; i++) begin
      if (reset_n && (rspv[i] != '0)) begin
        qs = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (qs == 0) begin
          check("unexpected_rsp", 64'(rspv[i]), 64'(0));
        end else begin
          if (i == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check("rsp_onehot", 64'(rspv[i]), 64'(1) << e.id);
          check("rsp_angle", ang[i], e.angle);
          check("rsp_timeout", 64'(tmo[i]), 64'(e.tmo));
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
          check("rsp_core_reset", 64'(crst[i]), 64'(1));
        end
      end
    end
  end

  task automatic wait_ready(input int inst, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (rdy[inst] != '0) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic check_reset_vals(input int inst);
    check("rst_req_ready", 64'(rdy[inst]), 64'(0));
    check("rst_rsp_valid", 64'(rspv[inst]), 64'(0));
    check("rst_rsp_angle", ang[inst], 64'(0));
    check("rst_rsp_timeout", 64'(tmo[inst]), 64'(0));
    check("rst_busy", 64'(busy[inst]), 64'(0));
    check("rst_core_enable", 64'(cen[inst]), 64'(0));
    check("rst_core_reset", 64'(crst[inst]), 64'(1));
    check("rst_core_arg1", ca1[inst], 64'(0));
    check("rst_core_arg2", ca2[inst], 64'(0));
  endtask

  // mode: 0 drop only the granted request, 1 keep all held, 2 drop all.
  task automatic run_job(input int inst, input logic [N-1:0] mask, input int mode,
                         input int lat, input logic signed [12:0] angle,
                         input logic never, input logic stale);
    int          g, a, lim;
    bit          ok;
    logic [63:0] e1, e2;
    exp_t        e;
    lim              = (inst == 0) ? TO_A : TO_B;
    stub_l[inst]     = lat;
    stub_ang[inst]   = angle;
    stub_never[inst] = never;
    stub_stale[inst] = stale;
    rv[inst]         = mask;
    for (int r = 0; r < N; r++) begin
      if (mask[r]) begin
        a1[inst][r*64 +: 64] = {$urandom, $urandom};
        a2[inst][r*64 +: 64] = {$urandom, $urandom};
      end
    end
    #1;
    g = rr_model(rv[inst], model_last[inst]);
    wait_ready(inst, ok);
    if (!ok) begin
      check("grant_wait", 64'(0), 64'(1));
      return;
    end
    a = cyc;
    check("grant_id", 64'(rdy[inst]), 64'(1) << g);
    e1       = a1[inst][g*64 +: 64];
    e2       = a2[inst][g*64 +: 64];
    e.id     = g;
    e.tmo    = never || (lat > lim);
    e.angle  = e.tmo ? 13'sd0 : angle;
    e.cyc    = a + 2 + (e.tmo ? lim : lat);
    if (inst == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
    model_last[inst] = g;
    @(posedge clk);
    #1;
    a1[inst] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a2[inst] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (mode == 0)      rv[inst][g] = 1'b0;
    else if (mode == 2) rv[inst]    = '0;
    @(negedge clk);
    check("run_core_arg1", ca1[inst], e1);
    check("run_core_arg2", ca2[inst], e2);
    check("run_core_enable", 64'(cen[inst]), 64'(1));
    check("run_core_reset", 64'(crst[inst]), 64'(0));
    ok = 1'b0;
    for (int k = 0; k < lim + 10 && !ok; k++) begin
      if (!busy[inst]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("busy_wait", 64'(0), 64'(1));
    end else begin
      check("hold_angle", ang[inst], e.angle);
      check("hold_timeout", 64'(tmo[inst]), 64'(e.tmo));
    end
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 2; i++) begin
      rv[i] = '1;
      a1[i] = '0;
      a2[i] = '0;
      stub_l[i]     = 1000;
      stub_ang[i]   = '0;
      stub_never[i] = 1'b0;
      stub_stale[i] = 1'b0;
      model_last[i] = N - 1;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rv[0]   = '0;
    rv[1]   = '0;
    reset_n = 1'b1;
    @(negedge clk);

    run_job(0, 3'b001, 2, 20, 13'sd804, 1'b0, 1'b0);
    run_job(0, 3'b101, 0, 7, -13'sd1000, 1'b0, 1'b0);
    run_job(0, 3'b001, 2, 3, 13'sd55, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job(0, 3'b111, (j == 5) ? 2 : 1, int'($urandom_range(1, 30)), 13'($urandom),
              1'b0, 1'b0);
    run_job(0, 3'b010, 2, 12, 13'sd321, 1'b0, 1'b1);
    run_job(0, 3'b100, 2, 1, -13'sd4096, 1'b0, 1'b0);
    for (int j = 0; j < 15; j++)
      run_job(0, N'($urandom_range(1, 7)), 2, int'($urandom_range(1, 40)), 13'($urandom),
              1'b0, 1'($urandom_range(0, 1)));

    // Reset in the middle of a running job.
    stub_l[0] = 20; stub_never[0] = 1'b0; stub_stale[0] = 1'b0;
    rv[0] = 3'b001;
    #1;
    wait_ready(0, ok);
    if (!ok) check("grant_wait_rst", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    rv[0] = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    rv[0]   = 3'b011;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    check_reset_vals(0);
    model_last[0] = N - 1;
    model_last[1] = N - 1;
    reset_n = 1'b1;
    run_job(0, 3'b011, 2, 4, 13'sd17, 1'b0, 1'b0);

    run_job(1, 3'b001, 2, 0, 13'sd99, 1'b1, 1'b0);
    run_job(1, 3'b010, 2, TO_B, 13'sd77, 1'b0, 1'b0);
    run_job(1, 3'b100, 2, 5, -13'sd5, 1'b0, 1'b0);
    run_job(1, 3'b111, 2, TO_B + 1, 13'sd123, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("drain_q0", 64'(exp_q0.size()), 64'(0));
    check("drain_q1", 64'(exp_q1.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
